// File: rtl/alu_sweep_checker_pkg.sv
// Shared definitions for the ALU sweep checker: opcode encodings, FSM states
// and a small width helper used for counter sizing.
package alu_sweep_checker_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } aluOpE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stateE;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cntWidth(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_sweep_checker_ref.sv
// Combinational golden ALU; same port shape as the ALU under test.
module alu_ref_model
  import alu_sweep_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OPW   = 2
) (
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] ans
);

  always_comb begin
    ans = '0;
    case (op)
      OPW'(OP_ADD): ans = inA + inB;
      OPW'(OP_SUB): ans = inA - inB;
      OPW'(OP_AND): ans = inA & inB;
      OPW'(OP_OR):  ans = inA | inB;
      default:      ans = '0;
    endcase
  end

endmodule

// File: rtl/alu_sweep_checker.sv
// BIST-style driver: sweeps every {op,a,b} into the ALU, checks alu_ans against
// the golden model after a settle window, and records mismatches.
module alu_sweep_checker
  import alu_sweep_checker_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned OPW    = 2,
  parameter int unsigned SETTLE = 0,
  parameter int unsigned ERRW   = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [OPW-1:0]          alu_op,
  input  logic [WIDTH-1:0]        alu_ans,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERRW-1:0]         err_count,
  output logic [OPW+2*WIDTH-1:0]  fail_vec,
  output logic [WIDTH-1:0]        fail_ans
);

  localparam int unsigned IDXW = OPW + 2 * WIDTH;
  localparam int unsigned SETW = cntWidth(SETTLE + 1);

  stateE            state;
  stateE            stateNext;
  logic [IDXW-1:0]  idx;
  logic [SETW-1:0]  settleCnt;
  logic [WIDTH-1:0] expAns;
  logic             sampleEdge;
  logic             lastVec;
  logic             beginSweep;
  logic             mismatch;

  // The vector register is the ALU drive; op slowest, b fastest.
  assign {alu_op, alu_a, alu_b} = idx;

  assign sampleEdge = (state == ST_RUN) && !abort && (settleCnt == SETW'(SETTLE));
  assign lastVec    = (idx == '1);
  assign beginSweep = start && (state != ST_RUN);
  assign mismatch   = sampleEdge && (alu_ans != expAns);

  assign busy = (state == ST_RUN);
  assign pass = done && (err_count == '0);

  alu_ref_model #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) uRef (
    .inA (alu_a),
    .inB (alu_b),
    .op  (alu_op),
    .ans (expAns)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (start) stateNext = ST_RUN;
      ST_RUN: begin
        if (abort)                      stateNext = ST_IDLE;
        else if (sampleEdge && lastVec) stateNext = ST_DONE;
      end
      ST_DONE: if (start) stateNext = ST_RUN;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      settleCnt <= '0;
      done      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      fail_ans  <= '0;
    end else if (beginSweep) begin
      idx       <= '0;
      settleCnt <= '0;
      done      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      fail_ans  <= '0;
    end else if (state == ST_RUN && !abort) begin
      if (sampleEdge) begin
        settleCnt <= '0;
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + ERRW'(1);
          // Empty counter means this is the sweep's first mismatch.
          if (err_count == '0) begin
            fail_vec <= idx;
            fail_ans <= alu_ans;
          end
        end
        if (lastVec) done <= 1'b1;
        else         idx  <= idx + IDXW'(1);
      end else begin
        settleCnt <= settleCnt + SETW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Scoreboard bench: expected sweep results are queued at start; monitors pop
// and compare on each rising edge of done.
module tb_alu_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n, start, abort, start2, abort2;
  int   faultMode;

  logic [3:0] a0, b0, ans0, fa0, a1, b1, ans1, fa1, a2, b2, ans2, fa2;
  logic [1:0] op0, op1, op2;
  logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [10:0] err0, err2;
  logic [3:0]  err1;
  logic [9:0]  fv0, fv1, fv2;

  function automatic logic [3:0] aluModel(logic [3:0] a, logic [3:0] b, logic [1:0] op, int fault);
    logic [3:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = (fault == 1) ? a + b : a - b;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    if (fault == 2) r[0] = 1'b0;
    return r;
  endfunction

  assign ans0 = aluModel(a0, b0, op0, faultMode);
  assign ans1 = aluModel(a1, b1, op1, faultMode);
  always @(posedge clk) ans2 <= aluModel(a2, b2, op2, 0);

  alu_sweep_checker dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_ans(ans0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_vec(fv0), .fail_ans(fa0)
  );

  alu_sweep_checker #(.ERRW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_ans(ans1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_vec(fv1), .fail_ans(fa1)
  );

  alu_sweep_checker #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .alu_a(a2), .alu_b(b2), .alu_op(op2), .alu_ans(ans2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_vec(fv2), .fail_ans(fa2)
  );

  typedef struct {
    int unsigned startCyc;
    int unsigned lat;
    logic [10:0] err;
    logic [3:0]  err1;
    logic [9:0]  vec;
    logic [3:0]  fans;
    logic        passV;
  } expT;

  expT q0[$];
  expT q2[$];
  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic prevDone0 = 1'b0;
  always @(negedge clk) begin : mon0
    expT e;
    if (rst_n && done0 && !prevDone0) begin
      if (q0.size() == 0) check("unexpected_done0", 32'(done0), 32'd0);
      else begin
        e = q0.pop_front();
        check("latency0", cyc - e.startCyc, e.lat);
        check("err_count0", 32'(err0), 32'(e.err));
        check("err_count_sat", 32'(err1), 32'(e.err1));
        check("fail_vec0", 32'(fv0), 32'(e.vec));
        check("fail_ans0", 32'(fa0), 32'(e.fans));
        check("pass0", 32'(pass0), 32'(e.passV));
        check("busy_at_done0", 32'(busy0), 32'd0);
      end
    end
    prevDone0 = done0;
  end

  logic prevDone2 = 1'b0;
  always @(negedge clk) begin : mon2
    expT e;
    if (rst_n && done2 && !prevDone2) begin
      if (q2.size() == 0) check("unexpected_done2", 32'(done2), 32'd0);
      else begin
        e = q2.pop_front();
        check("latency2", cyc - e.startCyc, e.lat);
        check("err_count2", 32'(err2), 32'(e.err));
        check("fail_vec2", 32'(fv2), 32'(e.vec));
        check("pass2", 32'(pass2), 32'(e.passV));
      end
    end
    prevDone2 = done2;
  end

  task automatic pulseStart();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulseStart2();
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
  endtask

  task automatic sweep0(int fault, logic [10:0] e, logic [3:0] e1, logic [9:0] v,
                        logic [3:0] fa, logic p);
    int unsigned n = 0;
    faultMode = fault;
    pulseStart();
    q0.push_back('{startCyc: cyc, lat: 1024, err: e, err1: e1, vec: v, fans: fa, passV: p});
    while (q0.size() != 0 && n < 1100) begin @(negedge clk); n++; end
    if (q0.size() != 0) begin
      check("timeout0", q0.size(), 0);
      q0.delete();
    end
  endtask

  initial begin
    int unsigned n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    faultMode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_pass", 32'(pass0), 0);
    check("rst_vec", 32'({op0, a0, b0}), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Correct ALU
    sweep0(0, 11'd0, 4'd0, 10'h000, 4'h0, 1'b1);
    // SUB computes a+b (starting from DONE)
    sweep0(1, 11'd224, 4'd15, 10'h101, 4'h1, 1'b0);
    // ans[0] stuck at 0
    sweep0(2, 11'd512, 4'd15, 10'h001, 4'h0, 1'b0);
    faultMode = 0;

    // SETTLE=2, registered ALU, extra starts mid-sweep
    pulseStart2();
    q2.push_back('{startCyc: cyc, lat: 3072, err: 11'd0, err1: 4'd0, vec: 10'h000, fans: 4'h0, passV: 1'b1});
    repeat (100) @(posedge clk);
    pulseStart2();
    repeat (1900) @(posedge clk);
    pulseStart2();
    n = 0;
    while (q2.size() != 0 && n < 1300) begin @(negedge clk); n++; end
    if (q2.size() != 0) begin
      check("timeout2", q2.size(), 0);
      q2.delete();
    end

    // Abort on the 10th edge after start
    pulseStart();
    repeat (9) @(posedge clk);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_busy", 32'(busy0), 0);
    check("abort_done", 32'(done0), 0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_hold_vec", 32'({op0, a0, b0}), 32'd9);
    check("abort_idle_done", 32'(done0), 0);
    sweep0(0, 11'd0, 4'd0, 10'h000, 4'h0, 1'b1);

    // Asynchronous reset mid-sweep
    faultMode = 1;
    pulseStart();
    repeat (499) @(posedge clk);
    @(negedge clk); #2; rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy0), 0);
    check("arst_err", 32'(err0), 0);
    check("arst_fail_vec", 32'(fv0), 0);
    check("arst_vec", 32'({op0, a0, b0}), 0);
    check("arst_done_pass", 32'({done0, pass0}), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_busy", 32'(busy0), 0);
    check("post_rst_vec", 32'({op0, a0, b0}), 0);
    check("post_rst_err", 32'(err0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
